// File: rtl/fifo_umbrales.sv
// fifo_umbrales: ingress buffer in front of the arqui input port.
// A small circular FIFO that absorbs bursts from the stimulus source and
// exports occupancy, full/empty and programmable almost-full/almost-empty
// thresholds ("umbrales") for upstream backpressure. Overflow and underflow
// attempts are dropped and leave a sticky error flag behind. The read data
// path is registered, and every status output is decoded from registers only.

module fifo_umbrales #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [ADDR_SIZE:0]   umbral_af_in,
   input  logic [ADDR_SIZE:0]   umbral_ae_in,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 valid_out,
   output logic [ADDR_SIZE:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 error
);

   localparam int DEPTH = 1 << ADDR_SIZE;

   // Occupancy-width constants. count is one bit wider than the pointers so
   // that it can represent a completely full buffer.
   localparam logic [ADDR_SIZE:0]   DEPTH_C   = (ADDR_SIZE+1)'(DEPTH);
   localparam logic [ADDR_SIZE:0]   CNT_ONE   = (ADDR_SIZE+1)'(1);
   localparam logic [ADDR_SIZE:0]   AF_RESET  = (ADDR_SIZE+1)'(DEPTH - 1);
   localparam logic [ADDR_SIZE:0]   AE_RESET  = (ADDR_SIZE+1)'(1);
   localparam logic [ADDR_SIZE-1:0] PTR_ONE   = ADDR_SIZE'(1);

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE-1:0] wptr;
   logic [ADDR_SIZE-1:0] rptr;
   logic [ADDR_SIZE:0]   umbral_af;
   logic [ADDR_SIZE:0]   umbral_ae;
   logic [ADDR_SIZE:0]   af_load;
   logic [ADDR_SIZE:0]   ae_load;

   logic pop_acc;
   logic push_acc;
   logic push_rej;
   logic pop_rej;

   // Request acceptance. A pop never bypasses an empty buffer, even with a
   // push in the same cycle. A push into a full buffer only succeeds when a
   // pop frees a slot on the same edge.
   always_comb begin
      pop_acc  = pop && (count != '0);
      push_acc = push && ((count != DEPTH_C) || pop_acc);
      push_rej = push && !push_acc;
      pop_rej  = pop && !pop_acc;
   end

   // Threshold sanitising. An almost-full threshold of zero would keep the
   // flag permanently on, so zero and anything beyond the buffer size both
   // clamp to DEPTH; the almost-empty threshold only needs the upper clamp.
   always_comb begin
      af_load = umbral_af_in;
      ae_load = umbral_ae_in;
      if ((umbral_af_in == '0) || (umbral_af_in > DEPTH_C)) begin
         af_load = DEPTH_C;
      end
      if (umbral_ae_in > DEPTH_C) begin
         ae_load = DEPTH_C;
      end
   end

   // Storage array. Contents after reset are irrelevant because count and the
   // pointers define what is valid, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wptr] <= data_in;
      end
   end

   // Write pointer, wrapping naturally modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
      end else if (push_acc) begin
         wptr <= wptr + PTR_ONE;
      end
   end

   // Read pointer plus the registered read port. When full with a
   // simultaneous push and pop, the read sees the old word at rptr because
   // the write to that slot lands on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rptr      <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= pop_acc;
         if (pop_acc) begin
            data_out <= mem[rptr];
            rptr     <= rptr + PTR_ONE;
         end
      end
   end

   // Occupancy counter; a matched push and pop leaves it unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (push_acc && !pop_acc) begin
         count <= count + CNT_ONE;
      end else if (pop_acc && !push_acc) begin
         count <= count - CNT_ONE;
      end
   end

   // Threshold registers reload every cycle init is held high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         umbral_af <= AF_RESET;
         umbral_ae <= AE_RESET;
      end else if (init) begin
         umbral_af <= af_load;
         umbral_ae <= ae_load;
      end
   end

   // Sticky error flag; init takes priority over a new error on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error <= 1'b0;
      end else if (init) begin
         error <= 1'b0;
      end else if (push_rej || pop_rej) begin
         error <= 1'b1;
      end
   end

   // Status flags decoded purely from registered state, so push and pop have
   // no combinational path to any output.
   always_comb begin
      full         = (count == DEPTH_C);
      empty        = (count == '0);
      almost_full  = (count >= umbral_af);
      almost_empty = (count <= umbral_ae);
   end

endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: directed scenarios followed by randomized traffic, with a
// queue-based reference model compared against the DUT on every falling edge.

module tb_fifo_umbrales;

   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic       init;
   logic [2:0] umbral_af_in;
   logic [2:0] umbral_ae_in;
   logic       push;
   logic [5:0] data_in;
   logic       pop;
   logic [5:0] data_out;
   logic       valid_out;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       error;

   int num_checks   = 0;
   int num_failures = 0;
   bit checking_on  = 1'b0;

   // Reference model state
   logic [5:0] q[$];
   logic [5:0] m_dout;
   bit         m_valid;
   bit         m_err;
   int         m_af;
   int         m_ae;
   bit         m_pa;
   bit         m_pu;

   fifo_umbrales #(.DATA_SIZE(6), .ADDR_SIZE(2)) dut (
      .clk(clk),
      .reset(reset),
      .init(init),
      .umbral_af_in(umbral_af_in),
      .umbral_ae_in(umbral_ae_in),
      .push(push),
      .data_in(data_in),
      .pop(pop),
      .data_out(data_out),
      .valid_out(valid_out),
      .count(count),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .error(error)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value against its expectation and tallies it
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Behavioural model: a bounded queue plus threshold and error bookkeeping
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_dout  = '0;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_af    = DEPTH - 1;
         m_ae    = 1;
      end else begin
         m_pa = pop && (q.size() > 0);
         m_pu = push && ((q.size() < DEPTH) || m_pa);
         m_valid = m_pa;
         if (m_pa) m_dout = q.pop_front();
         if (m_pu) q.push_back(data_in);
         if (init) m_err = 1'b0;
         else if ((push && !m_pu) || (pop && !m_pa)) m_err = 1'b1;
         if (init) begin
            m_af = (umbral_af_in == 0 || umbral_af_in > DEPTH) ? DEPTH : int'(umbral_af_in);
            m_ae = (umbral_ae_in > DEPTH) ? DEPTH : int'(umbral_ae_in);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (checking_on) begin
         checkOutput("cyc_count", 32'(count), 32'(q.size()));
         checkOutput("cyc_data_out", 32'(data_out), 32'(m_dout));
         checkOutput("cyc_valid_out", 32'(valid_out), 32'(m_valid));
         checkOutput("cyc_full", 32'(full), 32'(q.size() == DEPTH));
         checkOutput("cyc_empty", 32'(empty), 32'(q.size() == 0));
         checkOutput("cyc_almost_full", 32'(almost_full), 32'(int'(q.size()) >= m_af));
         checkOutput("cyc_almost_empty", 32'(almost_empty), 32'(int'(q.size()) <= m_ae));
         checkOutput("cyc_error", 32'(error), 32'(m_err));
      end
   end

   // Drives one cycle of inputs after the falling edge, then waits until just
   // past the next rising edge so the caller sees that edge's results
   task automatic applyStimulus(input bit p, input logic [5:0] d, input bit r,
                                input bit i, input logic [2:0] af,
                                input logic [2:0] ae);
      @(negedge clk);
      #1;
      push         = p;
      data_in      = d;
      pop          = r;
      init         = i;
      umbral_af_in = af;
      umbral_ae_in = ae;
      @(posedge clk);
      #1;
   endtask

   task automatic doPush(input logic [5:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0, 3'd3, 3'd1);
   endtask

   task automatic doPop();
      applyStimulus(1'b0, 6'h00, 1'b1, 1'b0, 3'd3, 3'd1);
   endtask

   task automatic doInit(input logic [2:0] af, input logic [2:0] ae);
      applyStimulus(1'b0, 6'h00, 1'b0, 1'b1, af, ae);
   endtask

   initial begin
      reset        = 1'b1;
      init         = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      data_in      = '0;
      umbral_af_in = 3'd3;
      umbral_ae_in = 3'd1;
      #12;
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_empty", 32'(empty), 32'd1);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_almost_empty", 32'(almost_empty), 32'd1);
      checkOutput("reset_almost_full", 32'(almost_full), 32'd0);
      checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
      checkOutput("reset_data_out", 32'(data_out), 32'd0);
      checkOutput("reset_error", 32'(error), 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      checking_on = 1'b1;

      // Fill with default thresholds 3/1
      doPush(6'h01);
      checkOutput("push1_count", 32'(count), 32'd1);
      checkOutput("push1_almost_empty", 32'(almost_empty), 32'd1);
      doPush(6'h02);
      checkOutput("push2_almost_empty", 32'(almost_empty), 32'd0);
      doPush(6'h03);
      checkOutput("push3_almost_full", 32'(almost_full), 32'd1);
      doPush(6'h04);
      checkOutput("push4_full", 32'(full), 32'd1);
      checkOutput("push4_count", 32'(count), 32'd4);

      // Overflow attempt is dropped
      doPush(6'h3F);
      checkOutput("ovf_error", 32'(error), 32'd1);
      checkOutput("ovf_count", 32'(count), 32'd4);

      // Drain in order
      for (int k = 1; k <= 4; k++) begin
         doPop();
         checkOutput("drain_data", 32'(data_out), 32'(k));
         checkOutput("drain_valid", 32'(valid_out), 32'd1);
      end
      checkOutput("drain_empty", 32'(empty), 32'd1);

      // Underflow with simultaneous push: pop rejected, push accepted
      doInit(3'd3, 3'd1);
      checkOutput("init_clears_error", 32'(error), 32'd0);
      applyStimulus(1'b1, 6'h15, 1'b1, 1'b0, 3'd3, 3'd1);
      checkOutput("unf_error", 32'(error), 32'd1);
      checkOutput("unf_count", 32'(count), 32'd1);
      checkOutput("unf_valid", 32'(valid_out), 32'd0);
      doPop();
      checkOutput("unf_next_data", 32'(data_out), 32'h15);

      // Full with simultaneous push and pop
      doInit(3'd3, 3'd1);
      for (int k = 0; k < 4; k++) doPush(6'(8'h10 + k));
      applyStimulus(1'b1, 6'h2A, 1'b1, 1'b0, 3'd3, 3'd1);
      checkOutput("fullpp_data", 32'(data_out), 32'h10);
      checkOutput("fullpp_count", 32'(count), 32'd4);
      checkOutput("fullpp_error", 32'(error), 32'd0);
      doPop();
      checkOutput("wrap_data1", 32'(data_out), 32'h11);
      doPop();
      checkOutput("wrap_data2", 32'(data_out), 32'h12);
      doPop();
      checkOutput("wrap_data3", 32'(data_out), 32'h13);
      doPop();
      checkOutput("wrap_data4", 32'(data_out), 32'h2A);

      // Programmed thresholds
      doPop();
      checkOutput("pre_init_error", 32'(error), 32'd1);
      doInit(3'd2, 3'd0);
      checkOutput("thr_error_cleared", 32'(error), 32'd0);
      doPush(6'h21);
      checkOutput("thr_ae_at1", 32'(almost_empty), 32'd0);
      doPush(6'h22);
      checkOutput("thr_af_at2", 32'(almost_full), 32'd1);
      doInit(3'd7, 3'd0);
      doPush(6'h23);
      checkOutput("thr_af7_at3", 32'(almost_full), 32'd0);
      doPush(6'h24);
      checkOutput("thr_af7_at4", 32'(almost_full), 32'd1);
      doPop();
      checkOutput("prereset_count", 32'(count), 32'd3);

      // Asynchronous reset mid-cycle
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("areset_count", 32'(count), 32'd0);
      checkOutput("areset_empty", 32'(empty), 32'd1);
      checkOutput("areset_almost_empty", 32'(almost_empty), 32'd1);
      checkOutput("areset_almost_full", 32'(almost_full), 32'd0);
      checkOutput("areset_data_out", 32'(data_out), 32'd0);
      checkOutput("areset_valid", 32'(valid_out), 32'd0);
      checkOutput("areset_error", 32'(error), 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      doPush(6'h31);
      checkOutput("postrst_ae", 32'(almost_empty), 32'd1);
      doPush(6'h32);
      doPush(6'h33);
      checkOutput("postrst_af", 32'(almost_full), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      @(negedge clk);
      #1;
      checking_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
      $finish;
   end

endmodule
